// File: rtl/event_encoder_8to3.sv
// event_encoder_8to3
// Sequential 8-to-3 encoder. Events on eight request lines are collected
// into a sticky pending register. The winning pending line is offered as a
// 3-bit code over a valid/ready handshake, and that line is cleared when the
// code is accepted. The code is bit-reversed: code = {i[0], i[1], i[2]}, so
// code[0] carries the index MSB. This matches the consumer-side 3-to-8
// decoder.
//
// All outputs come straight from registers. There is no combinational path
// from any input to any output.

module event_encoder_8to3 #(
   parameter bit PRIORITY_HIGH = 1'b1   // 1: highest index wins, 0: lowest
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       ready,
   input  logic       ovr_clr,
   output logic       valid,
   output logic [2:0] code,
   output logic [7:0] pending,
   output logic       overrun
);

   // The handshake state is the valid bit itself.
   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------

   // Bit-reverse a line index into the external code ordering.
   function automatic logic [2:0] code_from_idx(input logic [2:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

   // Recover the line index from a presented code. The reorder is its own
   // inverse, but a separate name keeps each call site readable.
   function automatic logic [2:0] idx_from_code(input logic [2:0] c);
      return {c[0], c[1], c[2]};
   endfunction

   // One-hot mask for a line index.
   function automatic logic [7:0] onehot(input logic [2:0] idx);
      logic [7:0] m;
      case (idx)
         3'd0:    m = 8'h01;
         3'd1:    m = 8'h02;
         3'd2:    m = 8'h04;
         3'd3:    m = 8'h08;
         3'd4:    m = 8'h10;
         3'd5:    m = 8'h20;
         3'd6:    m = 8'h40;
         3'd7:    m = 8'h80;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

   // Index of the highest set bit. Later matches overwrite earlier ones.
   // An empty vector returns 0, but callers only use the result when the
   // vector is non-zero.
   function automatic logic [2:0] pick_high(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         r = v[i] ? i[2:0] : r;
      end
      return r;
   endfunction

   // Index of the lowest set bit. The scan runs downwards, so the last
   // match is the lowest index.
   function automatic logic [2:0] pick_low(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         r = v[i] ? i[2:0] : r;
      end
      return r;
   endfunction

   // Arbitrate across the remaining lines and return the code in wire order.
   function automatic logic [2:0] pick(input logic [7:0] v);
      logic [2:0] idx;
      if (PRIORITY_HIGH) begin
         idx = pick_high(v);
      end else begin
         idx = pick_low(v);
      end
      return code_from_idx(idx);
   endfunction

   // ---------------------------------------------------------------------
   // State and next-state signals
   // ---------------------------------------------------------------------
   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] pend_r;
   logic [7:0] pend_nxt_s;
   logic [2:0] code_r;
   logic [2:0] code_nxt_s;
   logic       overrun_r;
   logic       overrun_nxt_s;

   logic       acc_s;
   logic [7:0] clr_mask_s;
   logic [7:0] remain_s;
   logic       ovr_hit_s;

   // Work out which line is being retired this cycle and what stays pending.
   always_comb begin
      acc_s = 1'b0;
      clr_mask_s = 8'h00;
      remain_s = pend_r;
      acc_s = (state_r == PRESENT) & ready;
      if (acc_s) begin
         clr_mask_s = onehot(idx_from_code(code_r));
      end else begin
         clr_mask_s = 8'h00;
      end
      remain_s = pend_r & ~clr_mask_s;
   end

   // Update the pending register and the sticky overrun flag.
   // A new event on a line that is being cleared in the same cycle lands on
   // an empty slot in remain_s. It therefore re-arms the line without
   // counting as an overrun. When ovr_clr and a new overrun happen together,
   // the new overrun wins.
   always_comb begin
      pend_nxt_s = remain_s | req;
      ovr_hit_s = |(req & remain_s);
      overrun_nxt_s = overrun_r;
      if (ovr_hit_s) begin
         overrun_nxt_s = 1'b1;
      end else if (ovr_clr) begin
         overrun_nxt_s = 1'b0;
      end else begin
         overrun_nxt_s = overrun_r;
      end
   end

   // Handshake FSM. Arbitration only happens when idle or when the current
   // code is accepted, so a presented code never changes while it is stalled.
   always_comb begin
      state_nxt_s = state_r;
      code_nxt_s = code_r;
      case (state_r)
         IDLE: begin
            if (|remain_s) begin
               state_nxt_s = PRESENT;
               code_nxt_s = pick(remain_s);
            end else begin
               state_nxt_s = IDLE;
               code_nxt_s = code_r;
            end
         end
         PRESENT: begin
            if (ready) begin
               if (|remain_s) begin
                  // Back-to-back issue: the next winner comes out with no bubble.
                  state_nxt_s = PRESENT;
                  code_nxt_s = pick(remain_s);
               end else begin
                  // Last line drained. The code keeps its final value.
                  state_nxt_s = IDLE;
                  code_nxt_s = code_r;
               end
            end else begin
               state_nxt_s = PRESENT;
               code_nxt_s = code_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            code_nxt_s = 3'b000;
         end
      endcase
   end

   // State registers. Reset is asynchronous and drops any presented code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         pend_r    <= 8'h00;
         code_r    <= 3'b000;
         overrun_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pend_r    <= pend_nxt_s;
         code_r    <= code_nxt_s;
         overrun_r <= overrun_nxt_s;
      end
   end

   assign valid   = (state_r == PRESENT);
   assign code    = code_r;
   assign pending = pend_r;
   assign overrun = overrun_r;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Testbench for event_encoder_8to3. A set-based reference model produces
// an expected snapshot after each edge and pushes it into a queue. A
// negedge monitor pops each snapshot and compares it with the DUT.

module tb_event_encoder_8to3;

   localparam bit PH = 1'b1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       ready;
   logic       ovr_clr;
   logic       valid;
   logic [2:0] code;
   logic [7:0] pending;
   logic       overrun;

   event_encoder_8to3 #(.PRIORITY_HIGH(PH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .ready   (ready),
      .ovr_clr (ovr_clr),
      .valid   (valid),
      .code    (code),
      .pending (pending),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [2:0] c;
      logic [7:0] p;
      logic       o;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: a set of pending lines, the presented line index
   // (-1 when nothing is presented), the last index presented, and the flag.
   bit m_set[8];
   int m_pres;
   int m_last;
   bit m_ovr;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int enc(input int idx);
      return ((idx & 1) << 2) | (idx & 2) | ((idx >> 2) & 1);
   endfunction

   function automatic int pick(input bit s[8]);
      int r;
      r = -1;
      if (PH) begin
         for (int i = 7; i >= 0; i--) if (s[i] && r < 0) r = i;
      end else begin
         for (int i = 0; i < 8; i++) if (s[i] && r < 0) r = i;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_set[i] = 1'b0;
      m_pres = -1;
      m_last = 0;
      m_ovr  = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] r, input logic rdy, input logic oc);
      bit rem[8];
      bit acc;
      bit hit;
      int p;
      acc = (m_pres >= 0) && rdy;
      for (int i = 0; i < 8; i++) rem[i] = m_set[i];
      if (acc) rem[m_pres] = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) if (r[i] && rem[i]) hit = 1'b1;
      if (hit) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
      if (m_pres < 0 || acc) begin
         p = pick(rem);
         m_pres = p;
         if (p >= 0) m_last = p;
      end
      for (int i = 0; i < 8; i++) m_set[i] = rem[i] | r[i];
   endtask

   task automatic push_exp();
      exp_t e;
      e.v = (m_pres >= 0);
      e.c = 3'(enc(m_last));
      for (int i = 0; i < 8; i++) e.p[i] = m_set[i];
      e.o = m_ovr;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs, let the edge happen, then queue the model's
   // expected result. The task returns 1 time unit after the edge.
   task automatic step(input logic [7:0] r, input logic rdy, input logic oc);
      req = r;
      ready = rdy;
      ovr_clr = oc;
      @(posedge clk);
      model_step(r, rdy, oc);
      push_exp();
      #1;
   endtask

   // Asynchronous reset between edges. The outputs must clear immediately.
   task automatic mid_reset(input string tag);
      #1 rst = 1'b1;
      #1;
      chk({tag, "_valid"}, {7'd0, valid}, 8'h00);
      chk({tag, "_pending"}, pending, 8'h00);
      chk({tag, "_overrun"}, {7'd0, overrun}, 8'h00);
      chk({tag, "_code"}, {5'd0, code}, 8'h00);
      exp_q.delete();
      model_reset();
      #1 rst = 1'b0;
   endtask

   // Monitor: compare every queued snapshot against the DUT on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("valid", {7'd0, valid}, {7'd0, e.v});
         chk("code", {5'd0, code}, {5'd0, e.c});
         chk("pending", pending, e.p);
         chk("overrun", {7'd0, overrun}, {7'd0, e.o});
      end
   end

   initial begin
      logic [7:0] rv;
      int dens;
      int rprob;

      // Reset with every request line asserted.
      rst = 1'b1;
      req = 8'hFF;
      ready = 1'b0;
      ovr_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {7'd0, valid}, 8'h00);
      chk("rst_pending", pending, 8'h00);
      chk("rst_code", {5'd0, code}, 8'h00);
      chk("rst_overrun", {7'd0, overrun}, 8'h00);
      rst = 1'b0;
      req = 8'h00;
      repeat (3) step(8'h00, 1'b0, 1'b0);

      // Single event on line 3.
      step(8'h08, 1'b1, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      chk("single_valid", {7'd0, valid}, 8'h01);
      chk("single_code", {5'd0, code}, 8'h06);
      step(8'h00, 1'b1, 1'b0);
      chk("single_done", {7'd0, valid}, 8'h00);

      // Stall on line 4, with line 7 arriving during the stall.
      step(8'h12, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      chk("stall_code", {5'd0, code}, 8'h01);
      step(8'h80, 1'b0, 1'b0);
      chk("stall_hold", {5'd0, code}, 8'h01);
      step(8'h00, 1'b1, 1'b0);
      chk("b2b_7", {5'd0, code}, 8'h07);
      step(8'h00, 1'b1, 1'b0);
      chk("b2b_1", {5'd0, code}, 8'h04);
      step(8'h00, 1'b1, 1'b0);
      chk("b2b_end", {7'd0, valid}, 8'h00);

      // Overrun: set, clear, and a clear that collides with a new overrun.
      step(8'h02, 1'b0, 1'b0);
      step(8'h02, 1'b0, 1'b0);
      chk("ovr_set", {7'd0, overrun}, 8'h01);
      step(8'h00, 1'b0, 1'b1);
      chk("ovr_clr", {7'd0, overrun}, 8'h00);
      step(8'h02, 1'b0, 1'b1);
      chk("ovr_set_wins", {7'd0, overrun}, 8'h01);
      step(8'h00, 1'b1, 1'b1);
      step(8'h00, 1'b1, 1'b0);

      // A new event on line 2 in the same cycle that line 2 is accepted.
      step(8'h04, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      step(8'h04, 1'b1, 1'b0);
      chk("coll_pend", pending, 8'h04);
      chk("coll_ovr", {7'd0, overrun}, 8'h00);
      step(8'h00, 1'b1, 1'b0);
      chk("coll_repr", {5'd0, code}, 8'h02);
      step(8'h00, 1'b1, 1'b0);

      // Asynchronous reset while a code is presented and overrun is set.
      step(8'h08, 1'b0, 1'b0);
      step(8'h08, 1'b0, 1'b0);
      mid_reset("async");

      // Randomised traffic with varying event density and consumer readiness.
      for (int blk = 0; blk < 12; blk++) begin
         dens  = $urandom_range(5, 60);
         rprob = $urandom_range(10, 100);
         for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 8; i++) rv[i] = ($urandom_range(0, 99) < dens);
            step(rv, ($urandom_range(0, 99) < rprob), ($urandom_range(0, 7) == 0));
         end
         if (blk % 4 == 3) mid_reset("rand_rst");
      end

      // Drain the remaining queued snapshots.
      step(8'h00, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("drain", 8'(exp_q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
